// File: rtl/lsu_ctrl_pkg.sv
// Shared types and request-decode helpers for the load/store unit.
// Encodings follow the RISC-V funct3 layout for loads and stores.
package lsu_ctrl_pkg;

   typedef enum logic [2:0] {
      LOAD_BYTE          = 3'b000,
      LOAD_HALF          = 3'b001,
      LOAD_WORD          = 3'b010,
      LOAD_DOUBLE        = 3'b011,
      LOAD_BYTE_UNSIGNED = 3'b100,
      LOAD_HALF_UNSIGNED = 3'b101,
      LOAD_WORD_UNSIGNED = 3'b110
   } load_type_t;

   typedef enum logic [2:0] {
      STORE_BYTE   = 3'b000,
      STORE_HALF   = 3'b001,
      STORE_WORD   = 3'b010,
      STORE_DOUBLE = 3'b011
   } store_type_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      RESP = 2'b11
   } lsu_state_t;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_MISALIGN = 2'b01,
      FAULT_TIMEOUT  = 2'b10,
      FAULT_ILLEGAL  = 2'b11
   } lsu_fault_t;

   function automatic logic is_illegal(logic is_store, logic [2:0] funct3, logic xlen64);
      if (is_store)
         return xlen64 ? (funct3 > STORE_DOUBLE) : (funct3 > STORE_WORD);
      return (funct3 == 3'b111) ||
             (!xlen64 && (funct3 == LOAD_DOUBLE || funct3 == LOAD_WORD_UNSIGNED));
   endfunction

   // Size is funct3[1:0] for both loads and stores.
   function automatic logic is_misaligned(logic [1:0] size, logic [2:0] addr_lo);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return addr_lo[0];
         2'd2:    return |addr_lo[1:0];
         default: return |addr_lo;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / data shift, and load extract with
// sign or zero extension.
module lsu_lane_align #(
   parameter int XLEN = 32
) (
   input  logic [1:0]                   st_size,
   input  logic [$clog2(XLEN/8)-1:0]    st_off,
   input  logic [XLEN-1:0]              st_wdata,
   output logic [XLEN/8-1:0]            be,
   output logic [XLEN-1:0]              wdata,
   input  logic [1:0]                   ld_size,
   input  logic                         ld_unsigned,
   input  logic [$clog2(XLEN/8)-1:0]    ld_off,
   input  logic [XLEN-1:0]              rdata,
   output logic [XLEN-1:0]              ld_data
);

   localparam int NB = XLEN / 8;

   logic [NB-1:0]   mask;
   logic [XLEN-1:0] lane;
   logic [XLEN-1:0] tmp;
   logic [6:0]      pad;

   always_comb begin
      case (st_size)
         2'd0:    mask = NB'(1);
         2'd1:    mask = NB'(3);
         2'd2:    mask = NB'(15);
         default: mask = '1;
      endcase
      be    = mask << st_off;
      wdata = st_wdata << {st_off, 3'b000};

      // Left-justify the loaded field, then shift it back down to extend.
      lane = rdata >> {ld_off, 3'b000};
      pad  = 7'(XLEN) - (7'd8 << ld_size);
      tmp  = lane << pad;
      // NOTE: kept out of a ?: with the unsigned branch; mixing them there
      // would turn the whole expression unsigned and >>> into a logical shift.
      if (ld_unsigned)
         ld_data = tmp >> pad;
      else
         ld_data = $signed(tmp) >>> pad;
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: decodes and checks one request, drives a valid/ready memory
// port with byte enables, and returns a single-cycle data or fault response.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_is_store,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   input  logic [4:0]          req_rd,
   output logic                rsp_valid,
   output logic [XLEN-1:0]     rsp_rdata,
   output logic [4:0]          rsp_rd,
   output logic                rsp_fault,
   output logic [1:0]          rsp_cause,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_be,
   input  logic                mem_rsp_valid,
   input  logic [XLEN-1:0]     mem_rdata,
   output logic                busy
);

   localparam int   NB     = XLEN / 8;
   localparam int   OFF_W  = $clog2(NB);
   localparam int   CNT_W  = $clog2(TIMEOUT + 1);
   localparam logic XLEN64 = (XLEN == 64);

   lsu_state_t       state_q, state_d;
   lsu_fault_t       cause_d;
   logic [CNT_W-1:0] cnt_q;
   logic             tmo;
   logic             is_store_q;
   logic [2:0]       funct3_q;
   logic [OFF_W-1:0] off_q;
   logic [NB-1:0]    be_w;
   logic [XLEN-1:0]  wdata_w;
   logic [XLEN-1:0]  ld_data_w;

   assign req_ready = (state_q == IDLE);
   assign tmo       = (cnt_q == CNT_W'(TIMEOUT - 1));

   lsu_lane_align #(.XLEN(XLEN)) u_lane (
      .st_size     (req_funct3[1:0]),
      .st_off      (req_addr[OFF_W-1:0]),
      .st_wdata    (req_wdata),
      .be          (be_w),
      .wdata       (wdata_w),
      .ld_size     (funct3_q[1:0]),
      .ld_unsigned (funct3_q[2]),
      .ld_off      (off_q),
      .rdata       (mem_rdata),
      .ld_data     (ld_data_w)
   );

   always_comb begin
      // NOTE: defaults first so every path assigns both signals; no latches.
      state_d = state_q;
      cause_d = FAULT_NONE;
      case (state_q)
         IDLE: if (req_valid) begin
            if (is_illegal(req_is_store, req_funct3, XLEN64)) begin
               state_d = RESP;
               cause_d = FAULT_ILLEGAL;
            end else if (is_misaligned(req_funct3[1:0], req_addr[2:0])) begin
               state_d = RESP;
               cause_d = FAULT_MISALIGN;
            end else begin
               state_d = REQ;
            end
         end
         // A response that lands on the last allowed cycle still wins over the timeout.
         REQ: begin
            if (mem_req_ready && mem_rsp_valid) state_d = RESP;
            else if (tmo) begin
               state_d = RESP;
               cause_d = FAULT_TIMEOUT;
            end else if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid) state_d = RESP;
            else if (tmo) begin
               state_d = RESP;
               cause_d = FAULT_TIMEOUT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         is_store_q    <= 1'b0;
         funct3_q      <= '0;
         off_q         <= '0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_rd        <= '0;
         rsp_fault     <= 1'b0;
         rsp_cause     <= FAULT_NONE;
         mem_req_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_be        <= '0;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_d;
         rsp_valid     <= (state_d == RESP);
         mem_req_valid <= (state_d == REQ);
         busy          <= (state_d != IDLE);

         if (state_q == IDLE)                       cnt_q <= '0;
         else if (state_q == REQ || state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);

         if (state_q == IDLE && req_valid) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            off_q      <= req_addr[OFF_W-1:0];
            rsp_rd     <= req_rd;
            if (state_d == REQ) begin
               mem_we    <= req_is_store;
               mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               mem_wdata <= wdata_w;
               mem_be    <= be_w;
            end
         end

         if (state_d == RESP && state_q != RESP) begin
            rsp_fault <= (cause_d != FAULT_NONE);
            rsp_cause <= cause_d;
            rsp_rdata <= (cause_d == FAULT_NONE && !is_store_q) ? ld_data_w : '0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench: an XLEN=32/TIMEOUT=4 instance and an XLEN=64 instance driven
// from one vector table, plus hand sequences for late responses and mid-flight reset.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        use64 = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_req_ready = 1'b0;
   logic        mem_rsp_valid = 1'b0;
   logic [63:0] mem_rdata = '0;

   always #5 clk = ~clk;

   logic        req_valid_32, req_valid_64;
   logic        req_ready_32, rsp_valid_32, rsp_fault_32, mreq_32, we_32, busy_32;
   logic        req_ready_64, rsp_valid_64, rsp_fault_64, mreq_64, we_64, busy_64;
   logic [31:0] rsp_rdata_32, mem_wdata_32, mem_addr_32, mem_addr_64;
   logic [63:0] rsp_rdata_64, mem_wdata_64;
   logic [4:0]  rsp_rd_32, rsp_rd_64;
   logic [1:0]  rsp_cause_32, rsp_cause_64;
   logic [3:0]  mem_be_32;
   logic [7:0]  mem_be_64;

   assign req_valid_32 = req_valid && !use64;
   assign req_valid_64 = req_valid && use64;

   lsu_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid_32), .req_ready(req_ready_32), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
      .rsp_valid(rsp_valid_32), .rsp_rdata(rsp_rdata_32), .rsp_rd(rsp_rd_32),
      .rsp_fault(rsp_fault_32), .rsp_cause(rsp_cause_32),
      .mem_req_valid(mreq_32), .mem_req_ready(mem_req_ready), .mem_we(we_32),
      .mem_addr(mem_addr_32), .mem_wdata(mem_wdata_32), .mem_be(mem_be_32),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0]), .busy(busy_32)
   );

   lsu_ctrl #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) dut64 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid_64), .req_ready(req_ready_64), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .rsp_valid(rsp_valid_64), .rsp_rdata(rsp_rdata_64), .rsp_rd(rsp_rd_64),
      .rsp_fault(rsp_fault_64), .rsp_cause(rsp_cause_64),
      .mem_req_valid(mreq_64), .mem_req_ready(mem_req_ready), .mem_we(we_64),
      .mem_addr(mem_addr_64), .mem_wdata(mem_wdata_64), .mem_be(mem_be_64),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy_64)
   );

   // Outputs of whichever instance the current vector targets.
   logic        m_req_ready, m_rsp_valid, m_rsp_fault, m_mreq, m_we, m_busy;
   logic [63:0] m_rsp_rdata, m_mem_wdata;
   logic [31:0] m_mem_addr;
   logic [7:0]  m_mem_be;
   logic [4:0]  m_rsp_rd;
   logic [1:0]  m_rsp_cause;

   assign m_req_ready = use64 ? req_ready_64 : req_ready_32;
   assign m_rsp_valid = use64 ? rsp_valid_64 : rsp_valid_32;
   assign m_rsp_fault = use64 ? rsp_fault_64 : rsp_fault_32;
   assign m_rsp_cause = use64 ? rsp_cause_64 : rsp_cause_32;
   assign m_rsp_rd    = use64 ? rsp_rd_64    : rsp_rd_32;
   assign m_rsp_rdata = use64 ? rsp_rdata_64 : {32'b0, rsp_rdata_32};
   assign m_mreq      = use64 ? mreq_64      : mreq_32;
   assign m_we        = use64 ? we_64        : we_32;
   assign m_mem_addr  = use64 ? mem_addr_64  : mem_addr_32;
   assign m_mem_wdata = use64 ? mem_wdata_64 : {32'b0, mem_wdata_32};
   assign m_mem_be    = use64 ? mem_be_64    : {4'b0, mem_be_32};
   assign m_busy      = use64 ? busy_64      : busy_32;

   typedef struct {
      bit          x64;
      bit          st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          waits;
      bit          no_ready;
      int          exp_lat;
      int          exp_mreq;
      bit          exp_fault;
      logic [1:0]  exp_cause;
      logic [63:0] exp_rdata;
      logic [7:0]  exp_be;
      logic [31:0] exp_maddr;
      logic [63:0] exp_wdata;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int c, nmreq;
      bit seen, mchk;
      @(negedge clk);
      use64        = v.x64;
      req_is_store = v.st;
      req_funct3   = v.f3;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      req_rd       = 5'(idx + 1);
      mem_rdata    = v.rdata;
      req_valid    = 1'b1;
      check($sformatf("v%0d req_ready", idx), 64'(m_req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      c = 1; nmreq = 0; seen = 1'b0; mchk = 1'b0;
      while (!seen && c <= 30) begin
         if (m_rsp_valid) begin
            seen = 1'b1;
         end else begin
            if (m_mreq) begin
               nmreq++;
               if (!mchk) begin
                  mchk = 1'b1;
                  check($sformatf("v%0d mem_addr", idx), 64'(m_mem_addr), 64'(v.exp_maddr));
                  check($sformatf("v%0d mem_be", idx), 64'(m_mem_be), 64'(v.exp_be));
                  check($sformatf("v%0d mem_we", idx), 64'(m_we), 64'(v.st));
                  if (v.st) check($sformatf("v%0d mem_wdata", idx), m_mem_wdata, v.exp_wdata);
               end
            end
            mem_req_ready = !v.no_ready;
            mem_rsp_valid = !v.no_ready && (c == 1 + v.waits);
            @(posedge clk); #1;
            c++;
         end
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (!seen) begin
         check($sformatf("v%0d response within bound", idx), 64'd0, 64'd1);
      end else begin
         check($sformatf("v%0d latency", idx), 64'(c), 64'(v.exp_lat));
         check($sformatf("v%0d rsp_fault", idx), 64'(m_rsp_fault), 64'(v.exp_fault));
         check($sformatf("v%0d rsp_cause", idx), 64'(m_rsp_cause), 64'(v.exp_cause));
         check($sformatf("v%0d rsp_rdata", idx), m_rsp_rdata, v.exp_rdata);
         check($sformatf("v%0d rsp_rd", idx), 64'(m_rsp_rd), 64'(idx + 1));
         check($sformatf("v%0d mem_req cycles", idx), 64'(nmreq), 64'(v.exp_mreq));
         @(posedge clk); #1;
         check($sformatf("v%0d rsp single pulse", idx), 64'(m_rsp_valid), 64'd0);
         check($sformatf("v%0d ready after resp", idx), 64'(m_req_ready), 64'd1);
      end
   endtask

   vec_t vecs[24];

   initial begin
      //            x64 st f3      addr          wdata                  rdata                  wt nr lat mq flt cause rdata                   be     maddr         wdata
      vecs[0]  = '{0, 0, 3'b000, 32'h1003, 64'h0,                 64'h80FF1234,          0, 0, 2, 1, 0, 2'd0, 64'hFFFFFF80,          8'h08, 32'h1000, 64'h0};
      vecs[1]  = '{0, 1, 3'b001, 32'h2002, 64'hABCD,              64'h0,                 3, 0, 5, 1, 0, 2'd0, 64'h0,                 8'h0C, 32'h2000, 64'hABCD0000};
      vecs[2]  = '{0, 0, 3'b010, 32'h3001, 64'h0,                 64'h0,                 0, 0, 1, 0, 1, 2'd1, 64'h0,                 8'h00, 32'h0,    64'h0};
      vecs[3]  = '{0, 0, 3'b011, 32'h3000, 64'h0,                 64'h0,                 0, 0, 1, 0, 1, 2'd3, 64'h0,                 8'h00, 32'h0,    64'h0};
      vecs[4]  = '{0, 0, 3'b010, 32'h4000, 64'h0,                 64'h0,                 0, 1, 5, 4, 1, 2'd2, 64'h0,                 8'h0F, 32'h4000, 64'h0};
      vecs[5]  = '{0, 0, 3'b101, 32'h5002, 64'h0,                 64'h87654321,          0, 0, 2, 1, 0, 2'd0, 64'h00008765,          8'h0C, 32'h5000, 64'h0};
      vecs[6]  = '{0, 0, 3'b001, 32'h5002, 64'h0,                 64'h87654321,          0, 0, 2, 1, 0, 2'd0, 64'hFFFF8765,          8'h0C, 32'h5000, 64'h0};
      vecs[7]  = '{0, 0, 3'b010, 32'h6004, 64'h0,                 64'hDEADBEEF,          1, 0, 3, 1, 0, 2'd0, 64'hDEADBEEF,          8'h0F, 32'h6004, 64'h0};
      vecs[8]  = '{0, 1, 3'b000, 32'h7001, 64'h5A,                64'h0,                 0, 0, 2, 1, 0, 2'd0, 64'h0,                 8'h02, 32'h7000, 64'h00005A00};
      vecs[9]  = '{0, 1, 3'b010, 32'h7003, 64'h0,                 64'h0,                 0, 0, 1, 0, 1, 2'd1, 64'h0,                 8'h00, 32'h0,    64'h0};
      vecs[10] = '{0, 1, 3'b011, 32'h7000, 64'h0,                 64'h0,                 0, 0, 1, 0, 1, 2'd3, 64'h0,                 8'h00, 32'h0,    64'h0};
      vecs[11] = '{0, 0, 3'b111, 32'h7000, 64'h0,                 64'h0,                 0, 0, 1, 0, 1, 2'd3, 64'h0,                 8'h00, 32'h0,    64'h0};
      vecs[12] = '{0, 0, 3'b100, 32'h1002, 64'h0,                 64'h80FF1234,          0, 0, 2, 1, 0, 2'd0, 64'h000000FF,          8'h04, 32'h1000, 64'h0};
      vecs[13] = '{0, 0, 3'b001, 32'h1001, 64'h0,                 64'h0,                 0, 0, 1, 0, 1, 2'd1, 64'h0,                 8'h00, 32'h0,    64'h0};
      vecs[14] = '{0, 0, 3'b010, 32'h4008, 64'h0,                 64'h0,                99, 0, 5, 1, 1, 2'd2, 64'h0,                 8'h0F, 32'h4008, 64'h0};
      vecs[15] = '{0, 0, 3'b110, 32'h1000, 64'h0,                 64'h0,                 0, 0, 1, 0, 1, 2'd3, 64'h0,                 8'h00, 32'h0,    64'h0};
      vecs[16] = '{1, 0, 3'b110, 32'h8004, 64'h0,                 64'h8000000112345678,  0, 0, 2, 1, 0, 2'd0, 64'h0000000080000001,  8'hF0, 32'h8000, 64'h0};
      vecs[17] = '{1, 0, 3'b010, 32'h8004, 64'h0,                 64'h8000000112345678,  0, 0, 2, 1, 0, 2'd0, 64'hFFFFFFFF80000001,  8'hF0, 32'h8000, 64'h0};
      vecs[18] = '{1, 0, 3'b011, 32'h8008, 64'h0,                 64'hFEDCBA9876543210,  2, 0, 4, 1, 0, 2'd0, 64'hFEDCBA9876543210,  8'hFF, 32'h8008, 64'h0};
      vecs[19] = '{1, 1, 3'b011, 32'h8010, 64'h1122334455667788,  64'h0,                 0, 0, 2, 1, 0, 2'd0, 64'h0,                 8'hFF, 32'h8010, 64'h1122334455667788};
      vecs[20] = '{1, 1, 3'b100, 32'h8000, 64'h0,                 64'h0,                 0, 0, 1, 0, 1, 2'd3, 64'h0,                 8'h00, 32'h0,    64'h0};
      vecs[21] = '{1, 0, 3'b011, 32'h8004, 64'h0,                 64'h0,                 0, 0, 1, 0, 1, 2'd1, 64'h0,                 8'h00, 32'h0,    64'h0};
      vecs[22] = '{1, 1, 3'b010, 32'h800C, 64'hCAFEF00D,          64'h0,                 0, 0, 2, 1, 0, 2'd0, 64'h0,                 8'hF0, 32'h8008, 64'hCAFEF00D00000000};
      vecs[23] = '{1, 0, 3'b111, 32'h8000, 64'h0,                 64'h0,                 0, 0, 1, 0, 1, 2'd3, 64'h0,                 8'h00, 32'h0,    64'h0};

      // Reset values on both instances.
      repeat (2) @(posedge clk);
      #1;
      check("reset req_ready32", 64'(req_ready_32), 64'd1);
      check("reset busy32", 64'(busy_32), 64'd0);
      check("reset rsp_valid32", 64'(rsp_valid_32), 64'd0);
      check("reset mem_req_valid32", 64'(mreq_32), 64'd0);
      check("reset mem_be32", 64'(mem_be_32), 64'd0);
      check("reset rsp_cause32", 64'(rsp_cause_32), 64'd0);
      check("reset req_ready64", 64'(req_ready_64), 64'd1);
      check("reset mem_addr64", 64'(mem_addr_64), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) run_vec(i, vecs[i]);

      // Late memory response after a timeout must be ignored in IDLE.
      run_vec(4, vecs[4]);
      mem_rsp_valid = 1'b1;
      mem_rdata     = 64'h12345678;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      check("late rsp no rsp_valid", 64'(m_rsp_valid), 64'd0);
      check("late rsp not busy", 64'(m_busy), 64'd0);
      @(posedge clk); #1;
      check("late rsp still quiet", 64'(m_rsp_valid), 64'd0);

      // Reset asserted while waiting for the memory response.
      @(negedge clk);
      use64        = 1'b0;
      req_is_store = 1'b0;
      req_funct3   = 3'b010;
      req_addr     = 32'h9000;
      req_valid    = 1'b1;
      @(posedge clk); #1;
      req_valid     = 1'b0;
      mem_req_ready = 1'b1;
      check("mid-rst mem_req_valid in REQ", 64'(m_mreq), 64'd1);
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      check("mid-rst busy in WAIT", 64'(m_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid-rst busy", 64'(m_busy), 64'd0);
      check("mid-rst mem_req_valid", 64'(m_mreq), 64'd0);
      check("mid-rst rsp_valid", 64'(m_rsp_valid), 64'd0);
      check("mid-rst mem_be", 64'(m_mem_be), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post-rst req_ready", 64'(m_req_ready), 64'd1);
      check("post-rst rsp_valid", 64'(m_rsp_valid), 64'd0);
      run_vec(0, vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
